// File: rtl/speckle_chip_model_if.sv
// ADC handshake between the controller and the speckle chip model.
// The controller raises i_adc_trigger and the chip answers with o_adc_done, o_adc_val and o_adc_busy.
//
// Handshake rules:
//   - A start request is a 0->1 transition of i_adc_trigger, sampled on clk.
//   - The request is accepted only while o_adc_busy is low.
//   - o_adc_busy stays high for the whole conversion.
//   - o_adc_done pulses for exactly one cycle and o_adc_busy drops in that same cycle.
//   - o_adc_val takes its new value together with o_adc_done and holds it until the next done.
interface speckle_chip_model_if #(
    parameter int NB_DATA = 12
) ();
    logic               i_adc_trigger;
    logic               o_adc_done;
    logic [NB_DATA-1:0] o_adc_val;
    logic               o_adc_busy;

    modport master (output i_adc_trigger, input o_adc_done, o_adc_val, o_adc_busy);
    modport slave  (input i_adc_trigger, output o_adc_done, o_adc_val, o_adc_busy);
endinterface

// File: rtl/speckle_chip_model.sv
// Stand-in for the speckle sensor die and its XADC channel.
// It decodes the shift-register pixel selection, stores key bits and answers conversions after a fixed latency.
module speckle_chip_model #(
    parameter int COLS         = 24,
    parameter int ROWS         = 24,
    parameter int NB_DATA      = 12,
    parameter int CONV_LATENCY = 26,
    localparam int NPIX        = COLS * ROWS,
    localparam int AW          = $clog2(NPIX)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_chip_col_clk,
    input  logic               i_chip_col_rst,
    input  logic               i_chip_col_data,
    input  logic               i_chip_row_clk,
    input  logic               i_chip_row_rst,
    input  logic               i_chip_row_data,
    input  logic               i_chip_row_ena,
    input  logic               i_chip_key_wren,
    speckle_chip_model_if.slave adc,
    input  logic               i_pix_we,
    input  logic [AW-1:0]      i_pix_addr,
    input  logic [NB_DATA-1:0] i_pix_data,
    input  logic [AW-1:0]      i_key_rd_addr,
    output logic               o_key_rd_data,
    output logic               o_sel_err,
    output logic               o_overrun,
    output logic               dbg_state
);
    localparam int CW  = $clog2(CONV_LATENCY);
    localparam int CIW = $clog2(COLS);
    localparam int RIW = $clog2(ROWS);

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} adc_state_e;

    logic col_clk_q, row_clk_q, key_wren_q, trig_q;
    logic col_edge, row_edge, key_edge, trig_edge;

    logic [COLS-1:0] col_sr;
    logic [ROWS-1:0] row_sr;
    logic [CIW-1:0]  col_idx;
    logic [RIW-1:0]  row_idx;
    logic            sel_valid;
    logic [AW-1:0]   sel_addr;

    logic [NPIX-1:0]    key_mem;
    logic [NB_DATA-1:0] pix_mem [NPIX];

    adc_state_e         state, state_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [NB_DATA-1:0] result, result_next;
    logic [NB_DATA-1:0] val_q, val_next;
    logic               done_q, done_next;
    logic               busy_q, busy_next;
    logic               sel_err_next, overrun_next;

    assign col_edge  = i_chip_col_clk & ~col_clk_q;
    assign row_edge  = i_chip_row_clk & ~row_clk_q;
    assign key_edge  = i_chip_key_wren & ~key_wren_q;
    assign trig_edge = adc.i_adc_trigger & ~trig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_clk_q  <= 1'b0;
            row_clk_q  <= 1'b0;
            key_wren_q <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            col_clk_q  <= i_chip_col_clk;
            row_clk_q  <= i_chip_row_clk;
            key_wren_q <= i_chip_key_wren;
            trig_q     <= adc.i_adc_trigger;
        end
    end

    // The clear input is level-sensitive and overrides any shift in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_sr <= '0;
            row_sr <= '0;
        end else begin
            if (i_chip_col_rst) col_sr <= '0;
            else if (col_edge)  col_sr <= {col_sr[COLS-2:0], i_chip_col_data};
            if (i_chip_row_rst) row_sr <= '0;
            else if (row_edge)  row_sr <= {row_sr[ROWS-2:0], i_chip_row_data};
        end
    end

    always_comb begin
        col_idx = '0;
        row_idx = '0;
        for (int i = 0; i < COLS; i++) if (col_sr[i]) col_idx = CIW'(i);
        for (int j = 0; j < ROWS; j++) if (row_sr[j]) row_idx = RIW'(j);
        sel_valid = $onehot(col_sr) && $onehot(row_sr) && i_chip_row_ena;
        sel_addr  = AW'(int'(row_idx) * COLS + int'(col_idx));
    end

    // Key writes use the selection and data bit seen before this edge, so a
    // simultaneous column shift never moves the target address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_mem       <= '0;
            o_key_rd_data <= 1'b0;
        end else begin
            if (key_edge && sel_valid) key_mem[sel_addr] <= i_chip_col_data;
            o_key_rd_data <= (int'(i_key_rd_addr) < NPIX) ? key_mem[i_key_rd_addr] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_pix_we) pix_mem[i_pix_addr] <= i_pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            result    <= '0;
            val_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            o_sel_err <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            result    <= result_next;
            val_q     <= val_next;
            done_q    <= done_next;
            busy_q    <= busy_next;
            o_sel_err <= sel_err_next;
            o_overrun <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        result_next  = result;
        val_next     = val_q;
        done_next    = 1'b0;
        busy_next    = busy_q;
        sel_err_next = o_sel_err;
        overrun_next = o_overrun;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    state_next   = CONV;
                    cnt_next     = CW'(CONV_LATENCY - 1);
                    busy_next    = 1'b1;
                    result_next  = sel_valid ? pix_mem[sel_addr] : '0;
                    sel_err_next = o_sel_err | ~sel_valid;
                end
            end
            CONV: begin
                if (trig_edge) overrun_next = 1'b1;
                if (cnt == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    val_next   = result;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign adc.o_adc_done = done_q;
    assign adc.o_adc_val  = val_q;
    assign adc.o_adc_busy = busy_q;
    assign dbg_state      = (state == CONV);
endmodule

// File: tb/tb_speckle_chip_model.sv
// Bench for speckle_chip_model: a queue-based reference model checked on every cycle,
// driven by directed scenarios followed by random pin activity.
module tb_speckle_chip_model;
    localparam int COLS = 24;
    localparam int ROWS = 24;
    localparam int NB   = 12;
    localparam int LAT  = 26;
    localparam int NPIX = COLS * ROWS;
    localparam int AW   = $clog2(NPIX);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic col_clk = 1'b0, col_rst = 1'b0, col_data = 1'b0;
    logic row_clk = 1'b0, row_rst = 1'b0, row_data = 1'b0, row_ena = 1'b0;
    logic key_wren = 1'b0;
    logic pix_we = 1'b0;
    logic [AW-1:0] pix_addr = '0;
    logic [NB-1:0] pix_data = '0;
    logic [AW-1:0] key_rd_addr = '0;
    logic key_rd_data, sel_err, overrun, dbg_state;

    int n_chk = 0;
    int n_fail = 0;

    speckle_chip_model_if #(.NB_DATA(NB)) adc ();

    speckle_chip_model #(.COLS(COLS), .ROWS(ROWS), .NB_DATA(NB), .CONV_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_chip_col_clk(col_clk), .i_chip_col_rst(col_rst), .i_chip_col_data(col_data),
        .i_chip_row_clk(row_clk), .i_chip_row_rst(row_rst), .i_chip_row_data(row_data),
        .i_chip_row_ena(row_ena), .i_chip_key_wren(key_wren),
        .adc(adc.slave),
        .i_pix_we(pix_we), .i_pix_addr(pix_addr), .i_pix_data(pix_data),
        .i_key_rd_addr(key_rd_addr), .o_key_rd_data(key_rd_data),
        .o_sel_err(sel_err), .o_overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit col_q[$];
    bit row_q[$];
    bit key_m[NPIX];
    logic [NB-1:0] pix_m[NPIX];
    bit p_cc, p_rc, p_kw, p_tr;
    bit started = 1'b0;
    bit pending;
    int cyc, accept_at, done_at;
    logic [NB-1:0] pend_val, exp_val;
    logic exp_done, exp_busy, exp_sel_err, exp_overrun, exp_key_rd;

    function automatic void decode(input bit q[$], output int n, output int idx);
        n = 0;
        idx = 0;
        foreach (q[i]) if (q[i]) begin n++; idx = i; end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int nc, ci, nr, ri, addr;
        bit valid;
        if (!rst_n) begin
            col_q = {};
            row_q = {};
            for (int i = 0; i < COLS; i++) col_q.push_back(1'b0);
            for (int i = 0; i < ROWS; i++) row_q.push_back(1'b0);
            foreach (key_m[i]) key_m[i] = 1'b0;
            {p_cc, p_rc, p_kw, p_tr} = '0;
            pending = 1'b0;
            cyc = 0;
            accept_at = 0;
            done_at = 0;
            exp_val = '0;
            {exp_done, exp_busy, exp_sel_err, exp_overrun, exp_key_rd} = '0;
            started = 1'b1;
        end else begin
            cyc++;
            decode(col_q, nc, ci);
            decode(row_q, nr, ri);
            valid = (nc == 1) && (nr == 1) && row_ena;
            addr = ri * COLS + ci;
            exp_key_rd = key_m[key_rd_addr];
            if (key_wren && !p_kw && valid) key_m[addr] = col_data;
            if (adc.i_adc_trigger && !p_tr) begin
                if (pending && cyc <= done_at) exp_overrun = 1'b1;
                else begin
                    pending = 1'b1;
                    accept_at = cyc;
                    done_at = cyc + LAT;
                    pend_val = valid ? pix_m[addr] : '0;
                    if (!valid) exp_sel_err = 1'b1;
                end
            end
            if (pix_we) pix_m[pix_addr] = pix_data;
            exp_done = pending && (cyc == done_at);
            if (exp_done) exp_val = pend_val;
            exp_busy = pending && (cyc >= accept_at) && (cyc < done_at);
            if (col_rst) foreach (col_q[i]) col_q[i] = 1'b0;
            else if (col_clk && !p_cc) begin col_q.push_front(col_data); void'(col_q.pop_back()); end
            if (row_rst) foreach (row_q[i]) row_q[i] = 1'b0;
            else if (row_clk && !p_rc) begin row_q.push_front(row_data); void'(row_q.pop_back()); end
            p_cc = col_clk;
            p_rc = row_clk;
            p_kw = key_wren;
            p_tr = adc.i_adc_trigger;
        end
    end

    // Compare process: every output, every cycle once the model has been reset.
    always @(negedge clk) begin
        if (started) begin
            chk("adc_done", adc.o_adc_done, exp_done);
            chk("adc_busy", adc.o_adc_busy, exp_busy);
            chk("adc_val", adc.o_adc_val, exp_val);
            chk("sel_err", sel_err, exp_sel_err);
            chk("overrun", overrun, exp_overrun);
            chk("key_rd_data", key_rd_data, exp_key_rd);
            chk("dbg_state", dbg_state, exp_busy);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic col_shift(input logic d);
        col_data = d; col_clk = 1'b1; tick();
        col_clk = 1'b0; tick();
    endtask

    task automatic row_shift(input logic d);
        row_data = d; row_clk = 1'b1; tick();
        row_clk = 1'b0; tick();
    endtask

    task automatic select(input int r, input int c);
        col_rst = 1'b1; row_rst = 1'b1; tick();
        col_rst = 1'b0; row_rst = 1'b0; tick();
        col_shift(1'b1);
        repeat (c) col_shift(1'b0);
        row_shift(1'b1);
        repeat (r) row_shift(1'b0);
        row_ena = 1'b1;
    endtask

    task automatic key_pulse(input logic d);
        col_data = d; key_wren = 1'b1; tick();
        key_wren = 1'b0; tick();
    endtask

    task automatic pix_write(input int a, input logic [NB-1:0] d);
        pix_we = 1'b1; pix_addr = AW'(a); pix_data = d; tick();
        pix_we = 1'b0;
    endtask

    // Returns the cycle index (0 = sampling edge) at which done is seen, -1 on timeout.
    task automatic trigger_wait(output int lat);
        adc.i_adc_trigger = 1'b1;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            adc.i_adc_trigger = 1'b0;
            @(negedge clk);
            if (adc.o_adc_done) begin lat = k; break; end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, ndone, found;
        adc.i_adc_trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", adc.o_adc_busy, 0);
        chk("reset_val", adc.o_adc_val, 0);
        chk("reset_flags", {sel_err, overrun}, 0);
        tick();

        for (int a = 0; a < NPIX; a++) pix_write(a, NB'($urandom_range(0, 4095)));

        // Valid selection: col 4, row 2 -> address 52.
        select(2, 4);
        pix_write(2 * COLS + 4, 12'hABC);
        trigger_wait(lat);
        chk("sel_latency", lat, LAT);
        chk("sel_val", adc.o_adc_val, 12'hABC);
        chk("sel_no_err", sel_err, 0);

        // Two ones in the column register make the selection invalid.
        select(2, 4);
        col_shift(1'b1);
        trigger_wait(lat);
        chk("inv_latency", lat, LAT);
        chk("inv_val", adc.o_adc_val, 0);
        chk("inv_sel_err", sel_err, 1);
        repeat (5) tick();
        chk("sel_err_sticky", sel_err, 1);

        // Key write at (row 5, col 7) = address 127.
        select(5, 7);
        key_pulse(1'b1);
        key_rd_addr = AW'(127);
        tick();
        @(negedge clk);
        chk("key_127", key_rd_data, 1);
        select(0, 0);
        row_ena = 1'b0;
        key_pulse(1'b1);
        key_rd_addr = AW'(0);
        tick();
        @(negedge clk);
        chk("key_0_no_ena", key_rd_data, 0);

        // Simultaneous col_clk and key_wren: write lands on the pre-shift column 3.
        select(0, 3);
        col_data = 1'b1; col_clk = 1'b1; key_wren = 1'b1; tick();
        col_clk = 1'b0; key_wren = 1'b0; tick();
        key_rd_addr = AW'(3);
        tick();
        @(negedge clk);
        chk("key_preshift_3", key_rd_data, 1);
        key_rd_addr = AW'(4);
        tick();
        @(negedge clk);
        chk("key_postshift_4", key_rd_data, 0);

        // Overrun: second edge 10 cycles after the first, then a back-to-back trigger.
        select(2, 4);
        adc.i_adc_trigger = 1'b1; tick();
        adc.i_adc_trigger = 1'b0; repeat (9) tick();
        adc.i_adc_trigger = 1'b1; tick();
        adc.i_adc_trigger = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (adc.o_adc_done) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("overrun_done_seen", found, 1);
        chk("overrun_flag", overrun, 1);
        adc.i_adc_trigger = 1'b1;
        @(posedge clk); #1;
        adc.i_adc_trigger = 1'b0;
        @(negedge clk);
        chk("back_to_back_busy", adc.o_adc_busy, 1);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (adc.o_adc_done) ndone++;
        end
        chk("back_to_back_dones", ndone, 1);

        // Random pin activity.
        for (int it = 0; it < 1500; it++) begin
            case ($urandom_range(0, 9))
                0: col_shift(1'($urandom_range(0, 1)));
                1: row_shift(1'($urandom_range(0, 1)));
                2: select($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
                3: begin row_ena = ~row_ena; tick(); end
                4: key_pulse(1'($urandom_range(0, 1)));
                5: begin adc.i_adc_trigger = 1'b1; tick(); adc.i_adc_trigger = 1'b0; tick(); end
                6: pix_write($urandom_range(0, NPIX - 1), NB'($urandom_range(0, 4095)));
                7: begin key_rd_addr = AW'($urandom_range(0, NPIX - 1)); tick(); end
                8: begin
                    col_data = 1'($urandom_range(0, 1));
                    col_clk = 1'b1; key_wren = 1'b1; tick();
                    col_clk = 1'b0; key_wren = 1'b0; tick();
                end
                default: repeat ($urandom_range(1, 5)) tick();
            endcase
        end

        // Reset in the middle of a conversion.
        repeat (30) tick();
        chk("sel_err_before_reset", sel_err, 1);
        adc.i_adc_trigger = 1'b1; tick();
        adc.i_adc_trigger = 1'b0; repeat (10) tick();
        rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("midrst_busy", adc.o_adc_busy, 0);
        chk("midrst_done", adc.o_adc_done, 0);
        chk("midrst_val", adc.o_adc_val, 0);
        chk("midrst_flags", {sel_err, overrun}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int a = 0; a < NPIX; a++) begin
            key_rd_addr = AW'(a);
            tick();
            @(negedge clk);
            chk("key_cleared", key_rd_data, 0);
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/speckle_chip_model.md
# speckle_chip_model

Synthesizable stand-in for the speckle sensor die plus its XADC channel, sitting at the far end of the controller's chip pins and ADC handshake. It receives the column/row shift-register protocol, decodes the one-hot pixel selection, stores key bits written through `key_wren`, and answers conversion triggers with the selected pixel's value after a fixed latency. It is used in loopback builds and benches in place of the physical chip and XADC.

## Interface
- COLS, 24, pixel columns (column shift-register length)
- ROWS, 24, pixel rows (row shift-register length)
- NB_DATA, 12, pixel/ADC word width
- CONV_LATENCY, 26, clk cycles from accepted trigger to `o_adc_done` (min 2)
- clk  in  1  single system clock; all chip pins are sampled in this domain
- rst_n  in  1  asynchronous, active-low reset
- i_chip_col_clk / i_chip_col_rst / i_chip_col_data  in  1 each  column register clock, clear (active-high), serial data
- i_chip_row_clk / i_chip_row_rst / i_chip_row_data / i_chip_row_ena  in  1 each  row register clock, clear, data, output enable
- i_chip_key_wren  in  1  key write strobe; key bit is carried on `i_chip_col_data`
- i_adc_trigger  in  1  conversion start (convst)
- o_adc_done  out  1  one-cycle end-of-conversion pulse
- o_adc_val  out  NB_DATA  conversion result, held until next done
- o_adc_busy  out  1  conversion in progress
- i_pix_we / i_pix_addr [clog2(COLS*ROWS)] / i_pix_data [NB_DATA]  in  bench/loader write port into the pixel image memory
- i_key_rd_addr  in  clog2(COLS*ROWS)  key map read address
- o_key_rd_data  out  1  key bit at `i_key_rd_addr`, registered
- o_sel_err  out  1  sticky: conversion accepted with invalid selection
- o_overrun  out  1  sticky: trigger edge seen while busy

## Operation
- Edge detect: every chip input and `i_adc_trigger` has a previous-value register (reset 0); rising edge = current 1 and previous 0.
- Column register `col_sr[COLS-1:0]`: `i_chip_col_rst` high clears it (priority over shift); else on col_clk edge `col_sr <= {col_sr[COLS-2:0], i_chip_col_data}`. Row register identical with row pins.
- Selection valid when `col_sr` is exactly one-hot, `row_sr` exactly one-hot, and `i_chip_row_ena`=1. Column index = set-bit position in `col_sr`, row index likewise; address = row*COLS + col.
- Key write: on key_wren edge with valid selection, `key_mem[address] <= i_chip_col_data`; invalid selection: no write. Same-cycle col_clk edge and key_wren edge: key uses pre-shift selection and pre-shift data sample.
- Pixel memory: `pix_mem[i_pix_addr] <= i_pix_data` when `i_pix_we`; contents undefined after reset (not cleared).
- ADC FSM, states IDLE, CONV:
  - IDLE: trigger edge -> latch result (pix_mem[address] if valid, else 0; set `o_sel_err` if invalid), load counter CONV_LATENCY-1, go CONV.
  - CONV: decrement; at 0 pulse `o_adc_done`, drive latched result on `o_adc_val`, return IDLE. Trigger edges in CONV are ignored and set `o_overrun`.
- Selection changes during CONV do not affect the latched result.
- Reset (any time, including mid-conversion): both shift registers 0, FSM IDLE, counter 0, all outputs 0, sticky flags cleared; key_mem cleared to 0.

## Timing
- Shift/clear/key write take effect at the clk edge where the input edge is detected; visible next cycle.
- Trigger edge sampled at edge N -> `o_adc_busy` high from N+1; `o_adc_done` high for exactly cycle N+CONV_LATENCY; `o_adc_busy` low from the same cycle; `o_adc_val` updates at that cycle.
- Back-to-back: new trigger edge accepted the cycle after done.
- `o_key_rd_data`: one-cycle read latency; a write and read of the same address in one cycle returns the old value.
- Level-held inputs produce a single action (edge only).

## Test plan
- Reset: hold rst_n=0 mid-conversion -> busy, done, val, flags all 0; key_rd returns 0 for all addresses.
- Selection: col_rst, shift 1 then 4 zeros on col; row 1 then 2 zeros; row_ena=1; pix_mem[2*24+4]=12'hABC; trigger -> done exactly 26 cycles later, val=12'hABC.
- Invalid selection: two 1s shifted into col; trigger -> val=0, o_sel_err=1 and stays 1 until reset.
- Key write: select (row 5, col 7), col_data=1, key_wren pulse -> key_rd_addr=127 reads 1 next cycle; with row_ena=0 repeated at (0,0) -> address 0 stays 0.
- Overrun/latency: trigger, second trigger edge 10 cycles later -> single done at +26, o_overrun=1; trigger the cycle after done -> accepted.
- Simultaneous col_clk and key_wren edge -> key written at pre-shift column address.
